// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control unit.
// Sequences each instruction through IF/ID/EXE/MEM/WB and decodes the datapath
// control strobes from the registered state and the instruction opcode.
// HALT reuses the ID encoding together with a sticky halt flag.
module multicycle_ctrl (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       RegDst,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIf    = 3'b000,
    StId    = 3'b001,
    StExeLs = 3'b010,
    StMem   = 3'b011,
    StWbL   = 3'b100,
    StExeB  = 3'b101,
    StExeA  = 3'b110,
    StWbA   = 3'b111
  } state_e;

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAnd   = 6'b010000;
  localparam logic [5:0] OpSlt   = 6'b100110;
  localparam logic [5:0] OpAddiu = 6'b000010;
  localparam logic [5:0] OpAndi  = 6'b010001;
  localparam logic [5:0] OpOri   = 6'b010010;
  localparam logic [5:0] OpSw    = 6'b110000;
  localparam logic [5:0] OpLw    = 6'b110001;
  localparam logic [5:0] OpBeq   = 6'b110100;
  localparam logic [5:0] OpBne   = 6'b110101;
  localparam logic [5:0] OpBltz  = 6'b110110;
  localparam logic [5:0] OpJ     = 6'b111000;
  localparam logic [5:0] OpHalt  = 6'b111111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;

  localparam logic [1:0] PcSeq    = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  state_e state_q, state_d;
  logic   halt_q;
  // Set on the first clock edge after reset release; outputs stay quiet until then.
  logic   active_q;

  logic op_r, op_imm, op_arith, op_sw, op_lw, op_ls;
  logic op_beq, op_bne, op_bltz, op_branch, op_j, op_halt, op_nop;
  logic op_and, op_or, op_slt;
  logic taken;
  logic run;

  // Opcode decode into instruction classes.
  always_comb begin
    op_r      = (opcode == OpAdd) || (opcode == OpSub) || (opcode == OpAnd) ||
                (opcode == OpSlt);
    op_imm    = (opcode == OpAddiu) || (opcode == OpAndi) || (opcode == OpOri);
    op_arith  = op_r || op_imm;
    op_sw     = (opcode == OpSw);
    op_lw     = (opcode == OpLw);
    op_ls     = op_sw || op_lw;
    op_beq    = (opcode == OpBeq);
    op_bne    = (opcode == OpBne);
    op_bltz   = (opcode == OpBltz);
    op_branch = op_beq || op_bne || op_bltz;
    op_j      = (opcode == OpJ);
    op_halt   = (opcode == OpHalt);
    op_nop    = !(op_arith || op_ls || op_branch || op_j || op_halt);
    op_and    = (opcode == OpAnd) || (opcode == OpAndi);
    op_or     = (opcode == OpOri);
    op_slt    = (opcode == OpSlt);
    taken     = (op_beq && zero) || (op_bne && !zero) || (op_bltz && sign);
  end

  // Outputs are live only once started after reset and while not halted.
  assign run   = active_q && !halt_q;
  assign state = state_q;

  // State, halt flag and start-up flag registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIf;
      halt_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (run) begin
        state_q <= state_d;
        if (state_q == StId && op_halt) begin
          halt_q <= 1'b1;
        end
      end
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = StIf;
    unique case (state_q)
      StIf: state_d = StId;
      StId: begin
        if (op_arith) begin
          state_d = StExeA;
        end else if (op_branch) begin
          state_d = StExeB;
        end else if (op_ls) begin
          state_d = StExeLs;
        end else if (op_halt) begin
          state_d = StId;
        end else begin
          state_d = StIf;
        end
      end
      StExeA:  state_d = StWbA;
      StWbA:   state_d = StIf;
      StExeB:  state_d = StIf;
      StExeLs: state_d = StMem;
      StMem:   state_d = op_lw ? StWbL : StIf;
      StWbL:   state_d = StIf;
      default: state_d = StIf;
    endcase
  end

  // Datapath control strobes.
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PcSeq;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    DBDataSrc = 1'b0;
    RegDst    = 1'b0;
    ALUOp     = AluAdd;
    if (run) begin
      RegDst  = op_r;
      ALUSrcB = op_imm || op_ls;
      ExtSel  = !((opcode == OpAndi) || (opcode == OpOri));
      if (op_branch) begin
        ALUOp = AluSub;
      end else if (op_and) begin
        ALUOp = AluAnd;
      end else if (op_or) begin
        ALUOp = AluOr;
      end else if (op_slt) begin
        ALUOp = AluSlt;
      end else begin
        ALUOp = AluAdd;
      end
      unique case (state_q)
        StIf: IRWre = 1'b1;
        StId: begin
          // j and NOP finish here; halt does not advance the PC.
          if (op_j) begin
            PCWre = 1'b1;
            PCSrc = PcJump;
          end else if (op_nop) begin
            PCWre = 1'b1;
          end
        end
        StExeB: begin
          PCWre = 1'b1;
          if (taken) begin
            PCSrc = PcBranch;
          end
        end
        StMem: begin
          mWR   = op_sw;
          mRD   = op_lw;
          PCWre = op_sw;
        end
        StWbA: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        StWbL: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          DBDataSrc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cases plus random instruction streams,
// compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       PCWre, IRWre, RegWre, mRD, mWR, ALUSrcB, ExtSel, DBDataSrc, RegDst;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp, state;
  logic [16:0] obs;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .opcode    (opcode),
    .zero      (zero),
    .sign      (sign),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .mRD       (mRD),
    .mWR       (mWR),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .DBDataSrc (DBDataSrc),
    .RegDst    (RegDst),
    .ALUOp     (ALUOp),
    .state     (state)
  );

  assign obs = {PCWre, PCSrc, IRWre, RegWre, mRD, mWR, ALUSrcB, ExtSel, DBDataSrc,
                RegDst, ALUOp, state};

  task automatic check_vec(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b  (PCWre,PCSrc,IRWre,RegWre,mRD,mWR,ALUSrcB,ExtSel,DBDataSrc,RegDst,ALUOp,state)",
               tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_r(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b000001 || op == 6'b010000 || op == 6'b100110;
  endfunction
  function automatic bit is_imm(input logic [5:0] op);
    return op == 6'b000010 || op == 6'b010001 || op == 6'b010010;
  endfunction
  function automatic bit is_br(input logic [5:0] op);
    return op == 6'b110100 || op == 6'b110101 || op == 6'b110110;
  endfunction

  // Cycles per instruction; halt is counted up to its ID cycle.
  function automatic int lat_of(input logic [5:0] op);
    if (is_r(op) || is_imm(op) || op == 6'b110000) return 4;
    if (op == 6'b110001) return 5;
    if (is_br(op)) return 3;
    return 2;
  endfunction

  // State code visited at step k of an instruction.
  function automatic logic [2:0] st_of(input logic [5:0] op, input int k);
    if (k == 0) return 3'b000;
    if (k == 1) return 3'b001;
    if (is_r(op) || is_imm(op)) return (k == 2) ? 3'b110 : 3'b111;
    if (is_br(op)) return 3'b101;
    if (k == 2) return 3'b010;
    if (k == 3) return 3'b011;
    return 3'b100;
  endfunction

  function automatic logic [16:0] exp_out(input logic [5:0] op, input int k, input logic z,
                                          input logic s);
    logic [2:0] st;
    logic       pcw, irw, rw, rd, wr, asb, ext, dbs, rdst;
    logic [1:0] src;
    logic [2:0] alu;
    bit         tk;
    st   = st_of(op, k);
    pcw  = (k == lat_of(op) - 1) && (op != 6'b111111);
    irw  = (k == 0);
    tk   = (op == 6'b110100 && z) || (op == 6'b110101 && !z) || (op == 6'b110110 && s);
    src  = (k == 1 && op == 6'b111000) ? 2'b10 : (st == 3'b101 && tk) ? 2'b01 : 2'b00;
    rw   = (st == 3'b111) || (st == 3'b100);
    wr   = (st == 3'b011) && op == 6'b110000;
    rd   = (st == 3'b011) && op == 6'b110001;
    dbs  = (st == 3'b100);
    rdst = is_r(op);
    asb  = is_imm(op) || op == 6'b110000 || op == 6'b110001;
    ext  = !(op == 6'b010001 || op == 6'b010010);
    if (is_br(op)) alu = 3'b001;
    else if (op == 6'b010000 || op == 6'b010001) alu = 3'b010;
    else if (op == 6'b010010) alu = 3'b011;
    else if (op == 6'b100110) alu = 3'b100;
    else alu = 3'b000;
    return {pcw, src, irw, rw, rd, wr, asb, ext, dbs, rdst, alu, st};
  endfunction

  // ---------------- stimulus ----------------
  // Entered just after a rising edge with the DUT in IF.
  // abort_k >= 0: pull Reset low just after sampling step abort_k.
  task automatic run_instr(input logic [5:0] op, input logic z, input logic s,
                           input int abort_k);
    opcode = op;
    for (int k = 0; k < lat_of(op); k++) begin
      if (st_of(op, k) == 3'b101) begin
        zero = z;
        sign = s;
      end else begin
        zero = 1'($urandom);
        sign = 1'($urandom);
      end
      @(negedge CLK);
      check_vec($sformatf("op%b step%0d", op, k), obs, exp_out(op, k, zero, sign));
      if (k == abort_k) begin
        #2 Reset = 1'b0;
        #1 check_vec($sformatf("async reset op%b step%0d", op, k), obs, 17'd0);
        return;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  // Holds Reset low across clock edges, releases it, and leaves the DUT in IF.
  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_vec("reset held", obs, 17'd0);
    Reset = 1'b1;
    #1 check_vec("released, before edge", obs, 17'd0);
    @(posedge CLK);
    #1;
  endtask

  logic [5:0] op_tab [13] = '{6'b000000, 6'b000001, 6'b010000, 6'b100110, 6'b000010,
                              6'b010001, 6'b010010, 6'b110000, 6'b110001, 6'b110100,
                              6'b110101, 6'b110110, 6'b111000};

  initial begin
    logic [5:0] op;
    do_reset();
    run_instr(6'b000000, 1'b0, 1'b0, -1);   // add
    run_instr(6'b110001, 1'b0, 1'b0, -1);   // lw
    run_instr(6'b110100, 1'b1, 1'b0, -1);   // beq taken
    run_instr(6'b110100, 1'b0, 1'b0, -1);   // beq not taken
    run_instr(6'b110110, 1'b0, 1'b1, -1);   // bltz taken
    run_instr(6'b110101, 1'b1, 1'b1, -1);   // bne not taken
    run_instr(6'b111000, 1'b0, 1'b0, -1);   // j
    run_instr(6'b101010, 1'b0, 1'b0, -1);   // undefined -> NOP
    run_instr(6'b010010, 1'b0, 1'b0, -1);   // ori
    run_instr(6'b110000, 1'b0, 1'b0, -1);   // sw

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) < 13) begin
        op = op_tab[$urandom_range(0, 12)];
      end else begin
        op = 6'($urandom);
        if (op == 6'b111111) op = 6'b101010;
      end
      run_instr(op, 1'($urandom), 1'($urandom), -1);
    end

    // sw aborted by reset in MEM
    run_instr(6'b110000, 1'b0, 1'b0, 3);
    do_reset();
    run_instr(6'b000010, 1'b0, 1'b0, -1);

    // halt: outputs stay quiet indefinitely
    run_instr(6'b111111, 1'b0, 1'b0, -1);
    @(posedge CLK);
    #1;
    for (int c = 0; c < 24; c++) begin
      zero = 1'($urandom);
      sign = 1'($urandom);
      @(negedge CLK);
      check_vec($sformatf("halted cycle%0d", c), obs, 17'b0_00_0_0_0_0_0_0_0_0_000_001);
    end
    do_reset();
    run_instr(6'b000001, 1'b0, 1'b0, -1);   // sub resumes from IF
    run_instr(6'b111000, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net: the stimulus is bounded, but never let a run hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000");
    $fatal(1);
  end

endmodule
